dmem_responder: RTL and testbench

Data-memory responder on the processor side of the data port. It accepts the pipeline's `memwrite`/`memread`, byte address (`exec_out`) and `write_data`, and returns `read_data`. Stores are posted into a small write buffer that drains into a single-port word RAM during idle cycles. Loads are serviced with one-cycle registered latency, and pending buffered stores are forwarded to them.

---
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: posted-store write buffer draining into a word RAM, registered loads.
// Define DMEM_FWD_EN to forward buffered stores to loads; otherwise matching loads stall.
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic                     memread,
  input  logic [31:0]              addr,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     stall,
  output logic                     misalign_err,
  output logic [$clog2(DEPTH):0]   wb_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       r_mem [2**ADDR_W];
  logic [ADDR_W-1:0] r_wb_addr [DEPTH];
  logic [31:0]       r_wb_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_read_data;
  logic              r_misalign;

  logic [ADDR_W-1:0] w_widx;
  logic              w_req;
  logic              w_misalign;
  logic              w_is_wr;
  logic              w_is_rd;
  logic              w_full;
  logic              w_stall_wr;
  logic              w_stall_rd;
  logic              w_push;
  logic              w_load;
  logic              w_drain;
  logic [31:0]       w_load_data;
  logic [DEPTH-1:0]  w_age_match;
  logic              w_unused;

  assign w_unused = ^addr[31:ADDR_W+2];

  assign w_widx     = addr[ADDR_W+1:2];
  assign w_req      = memwrite | memread;
  assign w_misalign = w_req && (addr[1:0] != 2'b00);
  assign w_is_wr    = memwrite & ~w_misalign;
  assign w_is_rd    = memread & ~memwrite & ~w_misalign;
  assign w_full     = (r_count == CNT_W'(DEPTH));

  // Age-ordered view of the buffer: index 0 is the oldest live entry.
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    logic [PTR_W-1:0] w_slot;
    assign w_slot         = r_head + PTR_W'(g);
    assign w_age_match[g] = (CNT_W'(g) < r_count) && (r_wb_addr[w_slot] == w_widx);
  end

`ifdef DMEM_FWD_EN
  logic [31:0] w_age_data [DEPTH];
  for (genvar g = 0; g < DEPTH; g++) begin : g_age_data
    assign w_age_data[g] = r_wb_data[g_age[g].w_slot];
  end

  // Scan oldest to newest so the youngest matching entry wins.
  always_comb begin
    w_load_data = r_mem[w_widx];
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (w_age_match[k]) begin
        w_load_data = w_age_data[k];
      end
    end
  end

  assign w_stall_rd = 1'b0;
`else
  assign w_load_data = r_mem[w_widx];
  assign w_stall_rd  = w_is_rd & (|w_age_match);
`endif

  assign w_stall_wr = w_is_wr & w_full;
  assign w_push     = w_is_wr & ~w_full;
  assign w_load     = w_is_rd & ~w_stall_rd;

  // A load blocked on a buffered match drains as if idle, so it eventually clears.
  assign w_drain = (r_count != '0) && (!w_req || w_stall_rd);

  assign stall = reset & (w_stall_wr | w_stall_rd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_read_data <= '0;
      r_misalign  <= 1'b0;
    end else begin
      if (w_misalign) begin
        r_misalign <= 1'b1;
      end
      if (w_push) begin
        r_tail  <= r_tail + PTR_W'(1);
        r_count <= r_count + CNT_W'(1);
      end else if (w_drain) begin
        r_head  <= r_head + PTR_W'(1);
        r_count <= r_count - CNT_W'(1);
      end
      if (w_load) begin
        r_read_data <= w_load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_tail] <= w_widx;
      r_wb_data[r_tail] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_drain) begin
      r_mem[r_wb_addr[r_head]] <= r_wb_data[r_head];
    end
  end

  assign read_data    = r_read_data;
  assign misalign_err = r_misalign;
  assign wb_count     = r_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default ADDR_W=8, DEPTH=4).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        stall;
  logic        misalign_err;
  logic [2:0]  wb_count;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned stall_cycles;

  dmem_responder #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memread      (memread),
    .addr         (addr),
    .write_data   (write_data),
    .read_data    (read_data),
    .stall        (stall),
    .misalign_err (misalign_err),
    .wb_count     (wb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    memwrite   = we;
    memread    = re;
    addr       = a;
    write_data = d;
  endtask

  task automatic idle();
    req(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    req(1'b1, 1'b0, a, d);
    tick();
  endtask

  // Holds a load until accepted, counting stalled cycles within a bound.
  task automatic load_hold(input logic [31:0] a);
    stall_cycles = 0;
    req(1'b0, 1'b1, a, '0);
    #1;
    while (stall && stall_cycles < 10) begin
      stall_cycles++;
      @(posedge clk);
      #2;
    end
    if (stall) check("load_stall_bound", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    req(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    tick();
    tick();
    check("rst_read_data", read_data, 32'h0);
    check("rst_wb_count", 32'(wb_count), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    reset = 1'b1;
    tick();

    // Seed RAM and set sticky error before mid-run reset
    store(32'h44, 32'hCAFE0001);
    idle();
    load_hold(32'h44);
    check("seed_load", read_data, 32'hCAFE0001);
    req(1'b0, 1'b1, 32'h45, '0);
    #1;
    check("misalign_ld_nostall", 32'(stall), 32'd0);
    tick();
    req(1'b0, 1'b0, '0, '0);
    check("misalign_ld_set", 32'(misalign_err), 32'd1);
    check("misalign_ld_rd_hold", read_data, 32'hCAFE0001);

    store(32'h80, 32'hA0A0A0A0);
    store(32'h84, 32'hB0B0B0B0);
    store(32'h88, 32'hC0C0C0C0);
    req(1'b0, 1'b0, '0, '0);
    check("pre_rst_count", 32'(wb_count), 32'd3);

    req(1'b1, 1'b0, 32'h8C, 32'hD0D0D0D0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_stall", 32'(stall), 32'd0);
    check("async_rst_count", 32'(wb_count), 32'd0);
    check("async_rst_rd", read_data, 32'h0);
    check("async_rst_misalign", 32'(misalign_err), 32'd0);
    req(1'b0, 1'b0, '0, '0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_count", 32'(wb_count), 32'd0);
    load_hold(32'h44);
    check("ram_kept_over_rst", read_data, 32'hCAFE0001);

    // Basic read-after-store through RAM
    store(32'h10, 32'hDEADBEEF);
    req(1'b0, 1'b0, '0, '0);
    check("store_count", 32'(wb_count), 32'd1);
    check("store_rd_hold", read_data, 32'hCAFE0001);
    idle();
    check("drain_count", 32'(wb_count), 32'd0);
    load_hold(32'h10);
    check("raw_data", read_data, 32'hDEADBEEF);
    check("raw_nostall", stall_cycles, 32'd0);

    // Same-address back-to-back stores then load
    store(32'h20, 32'h11111111);
    store(32'h20, 32'h22222222);
    load_hold(32'h20);
`ifdef DMEM_FWD_EN
    check("fwd_stall_cycles", stall_cycles, 32'd0);
    check("fwd_data", read_data, 32'h22222222);
    check("fwd_count", 32'(wb_count), 32'd2);
`else
    check("nofwd_stall_cycles", stall_cycles, 32'd2);
    check("nofwd_data", read_data, 32'h22222222);
    check("nofwd_count", 32'(wb_count), 32'd0);
`endif
    idle();
    idle();
    idle();
    check("drained_0x20", 32'(wb_count), 32'd0);
    load_hold(32'h20);
    check("ram_0x20", read_data, 32'h22222222);

    // Full buffer
    store(32'h30, 32'h30303030);
    store(32'h34, 32'h34343434);
    store(32'h38, 32'h38383838);
    store(32'h3C, 32'h3C3C3C3C);
    check("full_count", 32'(wb_count), 32'd4);
    req(1'b1, 1'b0, 32'h50, 32'h55555555);
    #1;
    check("full_stall", 32'(stall), 32'd1);
    tick();
    check("full_held_count", 32'(wb_count), 32'd4);
    idle();
    check("full_idle_drain", 32'(wb_count), 32'd3);
    req(1'b1, 1'b0, 32'h50, 32'h55555555);
    #1;
    check("full_retry_nostall", 32'(stall), 32'd0);
    tick();
    check("full_retry_count", 32'(wb_count), 32'd4);
    for (int unsigned i = 0; i < 4; i++) idle();
    check("full_drained", 32'(wb_count), 32'd0);
    load_hold(32'h50);
    check("full_5th_data", read_data, 32'h55555555);
    load_hold(32'h34);
    check("full_2nd_data", read_data, 32'h34343434);

    // Misaligned store is dropped
    req(1'b1, 1'b0, 32'h13, 32'h99999999);
    #1;
    check("misalign_st_nostall", 32'(stall), 32'd0);
    tick();
    req(1'b0, 1'b0, '0, '0);
    check("misalign_st_set", 32'(misalign_err), 32'd1);
    check("misalign_st_count", 32'(wb_count), 32'd0);
    idle();
    load_hold(32'h10);
    check("misalign_old_value", read_data, 32'hDEADBEEF);

    // Simultaneous write+read acts as a store
    req(1'b1, 1'b1, 32'h40, 32'h5);
    tick();
    req(1'b0, 1'b0, '0, '0);
    check("wr_rd_count", 32'(wb_count), 32'd1);
    check("wr_rd_rd_hold", read_data, 32'hDEADBEEF);
    idle();
    load_hold(32'h40);
    check("wr_rd_stored", read_data, 32'h5);
    check("misalign_sticky", 32'(misalign_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
